// File: rtl/cfg_update_scheduler.sv
// rtl/cfg_update_scheduler.sv - frame-aligned commit of async config words via 4-phase req/ack
// Shadow-registers a handshaken word and releases it to cfg_out on frame_start or force_apply.
module cfg_update_scheduler #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic              clk_dst,
  input  logic              rst_n,
  input  logic              req_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              frame_start,
  input  logic              force_apply,
  output logic              ack_out,
  output logic [DATA_W-1:0] cfg_out,
  output logic              cfg_update,
  output logic              pending,
  output logic              err,
  output logic [CNT_W-1:0]  update_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PENDING  = 2'd1,
    S_WAIT_LOW = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                req_s;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic [DATA_W-1:0]   cfg_q, cfg_d;
  logic                upd_q, upd_d;
  logic                pend_q, pend_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // req_in reaches the FSM only through this chain; data_in is trusted stable once req_s is seen.
  always_ff @(posedge clk_dst or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_dst or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      cfg_q    <= '0;
      upd_q    <= 1'b0;
      pend_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      upd_q    <= upd_d;
      pend_q   <= pend_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    upd_d    = 1'b0;
    pend_d   = pend_q;
    ack_d    = ack_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          shadow_d = data_in;
          pend_d   = 1'b1;
          state_d  = S_PENDING;
        end
      end
      S_PENDING: begin
        if (!req_s) begin
          // Source withdrew without an ack: drop the word and flag it permanently.
          err_d    = 1'b1;
          pend_d   = 1'b0;
          shadow_d = '0;
          state_d  = S_IDLE;
        end else if (frame_start || force_apply) begin
          cfg_d   = shadow_q;
          upd_d   = 1'b1;
          ack_d   = 1'b1;
          pend_d  = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_WAIT_LOW;
        end
      end
      S_WAIT_LOW: begin
        ack_d = 1'b1;
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        pend_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign ack_out      = ack_q;
  assign cfg_out      = cfg_q;
  assign cfg_update   = upd_q;
  assign pending      = pend_q;
  assign err          = err_q;
  assign update_count = cnt_q;

endmodule

// File: tb/tb_cfg_update_scheduler.sv
// tb/tb_cfg_update_scheduler.sv - randomized transaction-level check of cfg_update_scheduler
module tb_cfg_update_scheduler;

  logic        clk_dst = 1'b0;
  logic        rst_n;
  logic        req_in;
  logic [15:0] data_in;
  logic        frame_start;
  logic        force_apply;
  logic        ack_out;
  logic [15:0] cfg_out;
  logic        cfg_update;
  logic        pending;
  logic        err;
  logic [7:0]  update_count;

  cfg_update_scheduler #(.DATA_W(16), .SYNC_STAGES(2), .CNT_W(8)) dut (
    .clk_dst      (clk_dst),
    .rst_n        (rst_n),
    .req_in       (req_in),
    .data_in      (data_in),
    .frame_start  (frame_start),
    .force_apply  (force_apply),
    .ack_out      (ack_out),
    .cfg_out      (cfg_out),
    .cfg_update   (cfg_update),
    .pending      (pending),
    .err          (err),
    .update_count (update_count)
  );

  always #5 clk_dst = ~clk_dst;

  int checks = 0;
  int errors = 0;

  // Transaction-level expectations of the visible configuration state.
  logic [15:0] exp_cfg;
  logic [7:0]  exp_cnt;
  logic        exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_dst);
    #1;
  endtask

  // kind: 0 frame_start, 1 force_apply, 2 both, 3 source withdraws early.
  task automatic transfer(input logic [15:0] d, input int kind, input int dly, input bit coinc);
    data_in = d;
    req_in  = 1'b1;
    step();
    chk("pend_edge1", 32'(pending), 0);
    step();
    chk("pend_edge2", 32'(pending), 0);
    if (coinc) frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("pend_edge3", 32'(pending), 1);
    chk("no_early_upd", 32'(cfg_update), 0);
    chk("cfg_pre", 32'(cfg_out), 32'(exp_cfg));
    repeat (dly) begin
      step();
      chk("hold_pend", 32'(pending), 1);
      chk("hold_ack", 32'(ack_out), 0);
    end
    if (kind == 3) begin
      req_in  = 1'b0;
      data_in = 16'($urandom);
      step();
      step();
      chk("viol_pend_held", 32'(pending), 1);
      step();
      exp_err = 1'b1;
      chk("viol_err", 32'(err), 32'(exp_err));
      chk("viol_pend", 32'(pending), 0);
      chk("viol_ack", 32'(ack_out), 0);
      chk("viol_cfg", 32'(cfg_out), 32'(exp_cfg));
      step();
    end else begin
      frame_start = (kind != 1);
      force_apply = (kind != 0);
      step();
      frame_start = 1'b0;
      force_apply = 1'b0;
      exp_cfg = d;
      exp_cnt++;
      chk("commit_cfg", 32'(cfg_out), 32'(exp_cfg));
      chk("commit_upd", 32'(cfg_update), 1);
      chk("commit_ack", 32'(ack_out), 1);
      chk("commit_pend", 32'(pending), 0);
      chk("commit_cnt", 32'(update_count), 32'(exp_cnt));
      chk("commit_err", 32'(err), 32'(exp_err));
      for (int i = 0; i < 3; i++) begin
        frame_start = 1'($urandom);
        force_apply = 1'($urandom);
        step();
        chk("waitlow_upd", 32'(cfg_update), 0);
        chk("waitlow_cfg", 32'(cfg_out), 32'(exp_cfg));
        chk("waitlow_cnt", 32'(update_count), 32'(exp_cnt));
      end
      frame_start = 1'b0;
      force_apply = 1'b0;
      req_in = 1'b0;
      step();
      chk("ack_hold1", 32'(ack_out), 1);
      step();
      chk("ack_hold2", 32'(ack_out), 1);
      step();
      chk("ack_drop", 32'(ack_out), 0);
      step();
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    req_in      = 1'b0;
    data_in     = '0;
    frame_start = 1'b0;
    force_apply = 1'b0;
    exp_cfg     = '0;
    exp_cnt     = '0;
    exp_err     = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_cfg", 32'(cfg_out), 0);
    chk("rst_ack", 32'(ack_out), 0);
    chk("rst_pend", 32'(pending), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cnt", 32'(update_count), 0);
    chk("rst_upd", 32'(cfg_update), 0);

    transfer(16'h1234, 0, 7, 1'b0);
    transfer(16'h00FF, 1, 2, 1'b0);
    transfer(16'hA5C3, 0, 3, 1'b1);
    transfer(16'hDEAD, 3, 4, 1'b0);
    transfer(16'h0F0F, 2, 1, 1'b0);

    for (int n = 0; n < 300; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      transfer(16'($urandom), (r < 9) ? (r % 3) : 3, int'($urandom_range(0, 5)),
               ($urandom_range(0, 3) == 0));
    end
    while (exp_cnt != 8'd0) begin
      transfer(16'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
    end
    chk("cnt_wrap", 32'(update_count), 0);

    data_in = 16'h5A5A;
    req_in  = 1'b1;
    repeat (3) step();
    force_apply = 1'b1;
    step();
    force_apply = 1'b0;
    chk("mid_ack_pre", 32'(ack_out), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_ack_async", 32'(ack_out), 0);
    chk("mid_cfg", 32'(cfg_out), 0);
    chk("mid_cnt", 32'(update_count), 0);
    chk("mid_err", 32'(err), 0);
    req_in = 1'b0;
    step();
    step();
    rst_n   = 1'b1;
    exp_cfg = '0;
    exp_cnt = '0;
    exp_err = 1'b0;
    step();
    chk("post_rst_pend", 32'(pending), 0);
    chk("post_rst_ack", 32'(ack_out), 0);
    transfer(16'hBEEF, 1, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
